led_chaser: RTL and testbench
=============================

# led_chaser

Parametrised LED pattern generator that drives a bank of `N_LEDS` board LEDs from one clock. It sits between the board switches and the LED pins. It adds:
- an internal tick prescaler with four selectable speeds;
- a synchronous reset;
- a pause input;
- five display modes: shift up, shift down, bounce, bar fill, blink.

All pattern state advances only on prescaler ticks, so the LEDs are human-visible at board clock rates.

## Interface
Parameters:
- `N_LEDS`, default 18: number of LEDs; legal range 2..32.
- `DIV_W`, default 25: prescaler counter width; minimum 7.
- `POS_W`, default `$clog2(N_LEDS)`: width of `position`; derived, never overridden.

Ports:
- `Clock`, input, 1: sole clock; all logic is on its rising edge.
- `Reset`, input, 1: reset, synchronous and active-high.
- `mode`, input, 3: pattern select (see Operation); sampled every cycle.
- `speed`, input, 2: tick rate select.
- `pause`, input, 1: 1 freezes pattern state; the prescaler keeps running.
- `led`, output, `N_LEDS`: registered LED drive; bit 0 is the rightmost LED.
- `position`, output, `POS_W`: registered current index, always in 0..N_LEDS-1.
- `tick`, output, 1: registered one-cycle step strobe.

## Operation
Prescaler:
- `cnt` (`DIV_W` bits) increments every cycle and wraps naturally.
- Let K = `DIV_W` - 2*`speed`.
- `tick` is registered 1 in the cycle after the cycle in which the low K bits of `cnt` are all ones.
- Tick period is therefore 2^K cycles: speed 0 is slowest, speed 3 is fastest.

Step rule: the pattern advances on each edge where `tick`=1, `pause`=0 and `Reset`=0.

Per-mode behaviour on a step (mode encodings live in the package):
- 0 SHIFT_UP: `position`+1, wrapping N_LEDS-1 -> 0. `led` is one-hot at `position`.
- 1 SHIFT_DOWN: `position`-1, wrapping 0 -> N_LEDS-1. `led` is one-hot.
- 2 BOUNCE: uses direction register `dir` (0 = up).
  - dir=0: `position`+1; if `position` is N_LEDS-1, go to N_LEDS-2 and set dir=1.
  - dir=1: `position`-1; if `position` is 0, go to 1 and set dir=0.
  - Each endpoint is lit for exactly one tick. `led` is one-hot.
- 3 FILL: `position` advances as in SHIFT_UP. `led` bits [`position`:0] are set, all others 0.
- 4 BLINK: `phase` toggles. `led` is all ones when `phase`=1, all zeros otherwise. `position` is held.
- 5..7 reserved: `position`, `dir` and `phase` are held; `led` is all zeros.

Decode and mode changes:
- Every cycle, `led` <= decode(`mode`, next `position`, next `phase`).
- A mode change is therefore visible on `led` one cycle later, without waiting for a tick.
- A mode change never resets `position` or `dir`.

## Timing
- Reset values: `cnt`=0, `tick`=0, `position`=0, `dir`=0, `phase`=0, `led`=0.
- First cycle after `Reset` deasserts: `led` shows the decode of position 0 (e.g. 0x00001 in SHIFT_UP).
- `Reset` asserted mid-pattern: all state returns to reset values on that edge and overrides a coincident tick.
- Latency: `position` updates on the tick edge; `led` reflects the new position on the same edge.
- First tick after reset occurs 2^K cycles after reset release.
- `speed` change takes effect at the next point where the low K bits of `cnt` are all ones; there is no counter restart.
- `pause`=1 on a tick edge drops that step. The tick is not queued.

## Structure
- Package `led_chaser_pkg`: mode encodings `MODE_SHIFT_UP`..`MODE_BLINK` as 3-bit localparams, plus the one-hot and bar decode functions.
- Sub-module `tick_divider` (params `DIV_W`; ports `Clock`, `Reset`, `speed`, `tick`) holds the prescaler.
- The top level holds the state registers and the decode.

## Test plan
All scenarios use `N_LEDS`=5 and `DIV_W`=8, so speed 3 gives a tick every 4 cycles.
- Reset release, mode 0, speed 3 -> `led` 00001, then 00010 at the first tick; after 5 ticks `led`=00001 again (wrap).
- Mode 1 from reset -> first tick gives `position`=4, `led`=10000; then 01000.
- Mode 2, 10 ticks -> `position` sequence 1,2,3,4,3,2,1,0,1,2.
- Mode 3 -> `led` sequence 00011, 00111, 01111, 11111, 00001.
- Mode 4 -> `led` alternates 11111 / 00000 per tick; `position` stays constant. Switch to mode 6 -> `led`=00000 next cycle with `position` unchanged.
- `pause`=1 across 3 ticks -> `position` frozen, `tick` still pulses. Assert `Reset` coincident with a tick -> `position`=0, `led`=0.

Source files
------------

// File: rtl/led_chaser_pkg.sv
// Shared mode encodings and LED decode helpers for the LED chaser.
package led_chaser_pkg;

  localparam logic [2:0] MODE_SHIFT_UP   = 3'd0;
  localparam logic [2:0] MODE_SHIFT_DOWN = 3'd1;
  localparam logic [2:0] MODE_BOUNCE     = 3'd2;
  localparam logic [2:0] MODE_FILL       = 3'd3;
  localparam logic [2:0] MODE_BLINK      = 3'd4;

  function automatic logic [31:0] onehot(input logic [4:0] pos);
    return 32'd1 << pos;
  endfunction

  // Bits [pos:0] set; the double shift keeps pos=31 from overflowing.
  function automatic logic [31:0] bar(input logic [4:0] pos);
    return ~((32'hFFFF_FFFF << pos) << 1);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running prescaler producing a registered one-cycle step strobe.
module tick_divider
  import led_chaser_pkg::*;
#(
  parameter int DIV_W = 25
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] speed,
  output logic       tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] mask;
  logic             hit;

  // Low K = DIV_W - 2*speed bits set.
  always_comb begin
    mask = {DIV_W{1'b1}} >> {speed, 1'b0};
    hit  = (cnt & mask) == mask;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= hit;
    end
  end

endmodule

// File: rtl/led_chaser.sv
// LED pattern generator: shift, bounce, fill and blink modes
// stepped by a selectable-rate prescaler tick.
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int N_LEDS = 18,
  parameter int DIV_W  = 25,
  parameter int POS_W  = $clog2(N_LEDS)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [2:0]        mode,
  input  logic [1:0]        speed,
  input  logic              pause,
  output logic [N_LEDS-1:0] led,
  output logic [POS_W-1:0]  position,
  output logic              tick
);

  localparam logic [POS_W-1:0] LAST = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0] ONE  = POS_W'(1);

  logic              dir;
  logic              phase;
  logic              step;
  logic              dir_n;
  logic              phase_n;
  logic [POS_W-1:0]  inc;
  logic [POS_W-1:0]  dec;
  logic [POS_W-1:0]  pos_n;
  logic [N_LEDS-1:0] led_n;

  tick_divider #(
    .DIV_W(DIV_W)
  ) u_div (
    .Clock(Clock),
    .Reset(Reset),
    .speed(speed),
    .tick (tick)
  );

  always_comb begin
    step    = tick && !pause;
    inc     = (position == LAST) ? '0 : position + ONE;
    dec     = (position == '0) ? LAST : position - ONE;
    pos_n   = position;
    dir_n   = dir;
    phase_n = phase;
    if (step) begin
      case (mode)
        MODE_SHIFT_UP,
        MODE_FILL:       pos_n = inc;
        MODE_SHIFT_DOWN: pos_n = dec;
        MODE_BOUNCE: begin
          if (!dir) begin
            if (position == LAST) begin
              pos_n = LAST - ONE;
              dir_n = 1'b1;
            end else begin
              pos_n = position + ONE;
            end
          end else begin
            if (position == '0) begin
              pos_n = ONE;
              dir_n = 1'b0;
            end else begin
              pos_n = position - ONE;
            end
          end
        end
        MODE_BLINK:      phase_n = !phase;
        default:         ;
      endcase
    end
  end

  // Decode runs every cycle so mode changes show without a tick.
  always_comb begin
    led_n = '0;
    case (mode)
      MODE_SHIFT_UP,
      MODE_SHIFT_DOWN,
      MODE_BOUNCE: led_n = N_LEDS'(onehot(5'(pos_n)));
      MODE_FILL:   led_n = N_LEDS'(bar(5'(pos_n)));
      MODE_BLINK:  led_n = {N_LEDS{phase_n}};
      default:     led_n = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      position <= '0;
      dir      <= 1'b0;
      phase    <= 1'b0;
      led      <= '0;
    end else begin
      position <= pos_n;
      dir      <= dir_n;
      phase    <= phase_n;
      led      <= led_n;
    end
  end

endmodule

// File: tb/tb_led_chaser.sv
// Self-checking bench for led_chaser (N_LEDS=5, DIV_W=8).
module tb_led_chaser;
  import led_chaser_pkg::*;

  localparam int N = 5;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] mode = 3'd0;
  logic [1:0] speed = 2'd3;
  logic       pause = 1'b0;
  logic [N-1:0] led;
  logic [2:0] position;
  logic       tick;

  int tests = 0;
  int fails = 0;

  int m_cnt, m_pos, m_led;
  bit m_tick, m_dir, m_phase;

  led_chaser #(.N_LEDS(N), .DIV_W(DW)) dut (
    .Clock   (clk),
    .Reset   (rst),
    .mode    (mode),
    .speed   (speed),
    .pause   (pause),
    .led     (led),
    .position(position),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  // Advance one clock; reference model follows the behavioural rules.
  task automatic clk_step();
    bit stp;
    int k;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_tick = 0; m_pos = 0;
      m_dir = 0; m_phase = 0; m_led = 0;
    end else begin
      stp = m_tick && !pause;
      if (stp) begin
        case (mode)
          3'd0, 3'd3: m_pos = (m_pos + 1) % N;
          3'd1: m_pos = (m_pos + N - 1) % N;
          3'd2: begin
            if (!m_dir) begin
              if (m_pos == N - 1) begin m_pos = N - 2; m_dir = 1; end
              else m_pos++;
            end else begin
              if (m_pos == 0) begin m_pos = 1; m_dir = 0; end
              else m_pos--;
            end
          end
          3'd4: m_phase = !m_phase;
          default: ;
        endcase
      end
      k = DW - 2 * int'(speed);
      m_tick = (m_cnt % (1 << k)) == (1 << k) - 1;
      m_cnt = (m_cnt + 1) % (1 << DW);
      case (mode)
        3'd0, 3'd1, 3'd2: m_led = 1 << m_pos;
        3'd3: m_led = (1 << (m_pos + 1)) - 1;
        3'd4: m_led = m_phase ? (1 << N) - 1 : 0;
        default: m_led = 0;
      endcase
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_step();
    clk_step();
    rst = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 1000) begin
      clk_step();
      n++;
    end
    if (tick !== 1'b1) begin
      tests++; fails++;
      $display("FAIL %s tick_timeout: tick=%b after %0d cycles, want 1", name, tick, n);
    end
  endtask

  task automatic test_reset();
    mode = MODE_SHIFT_UP; speed = 2'd3; pause = 1'b0;
    do_reset();
    tests++;
    if (led !== 5'b0 || position !== 3'd0 || tick !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: led=%b pos=%0d tick=%b, want 00000 0 0", led, position, tick);
    end
    clk_step();
    tests++;
    if (led !== 5'b00001 || position !== 3'd0) begin
      fails++;
      $display("FAIL reset_release: led=%b pos=%0d, want 00001 0", led, position);
    end
  endtask

  task automatic test_shift_up();
    int t0;
    mode = MODE_SHIFT_UP; speed = 2'd3;
    do_reset();
    t0 = 0;
    while (tick !== 1'b1 && t0 < 20) begin clk_step(); t0++; end
    tests++;
    if (t0 != 4) begin
      fails++;
      $display("FAIL first_tick_latency: %0d cycles, want 4", t0);
    end
    clk_step();
    tests++;
    if (led !== 5'b00010 || position !== 3'd1) begin
      fails++;
      $display("FAIL shift_up_first: led=%b pos=%0d, want 00010 1", led, position);
    end
    for (int i = 0; i < 4; i++) begin wait_tick("shift_up"); clk_step(); end
    tests++;
    if (led !== 5'b00001 || position !== 3'd0) begin
      fails++;
      $display("FAIL shift_up_wrap: led=%b pos=%0d, want 00001 0", led, position);
    end
  endtask

  task automatic test_shift_down();
    mode = MODE_SHIFT_DOWN; speed = 2'd3;
    do_reset();
    wait_tick("shift_down"); clk_step();
    tests++;
    if (led !== 5'b10000 || position !== 3'd4) begin
      fails++;
      $display("FAIL shift_down_wrap: led=%b pos=%0d, want 10000 4", led, position);
    end
    wait_tick("shift_down"); clk_step();
    tests++;
    if (led !== 5'b01000 || position !== 3'd3) begin
      fails++;
      $display("FAIL shift_down_step: led=%b pos=%0d, want 01000 3", led, position);
    end
  endtask

  task automatic test_bounce();
    int exp_pos[10] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
    mode = MODE_BOUNCE; speed = 2'd3;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      wait_tick("bounce"); clk_step();
      tests++;
      if (position !== 3'(exp_pos[i]) || led !== 5'(1 << exp_pos[i])) begin
        fails++;
        $display("FAIL bounce_step%0d: pos=%0d led=%b, want pos=%0d", i, position, led, exp_pos[i]);
      end
    end
  endtask

  task automatic test_fill();
    int exp_led[5] = '{3, 7, 15, 31, 1};
    mode = MODE_FILL; speed = 2'd3;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wait_tick("fill"); clk_step();
      tests++;
      if (led !== 5'(exp_led[i])) begin
        fails++;
        $display("FAIL fill_step%0d: led=%b, want %b", i, led, 5'(exp_led[i]));
      end
    end
  endtask

  task automatic test_blink();
    logic [2:0] p0;
    mode = MODE_SHIFT_UP; speed = 2'd3;
    do_reset();
    wait_tick("blink"); clk_step();
    wait_tick("blink"); clk_step();
    mode = MODE_BLINK;
    p0 = position;
    for (int i = 0; i < 4; i++) begin
      wait_tick("blink"); clk_step();
      tests++;
      if (led !== ((i % 2 == 0) ? 5'b11111 : 5'b00000) || position !== p0) begin
        fails++;
        $display("FAIL blink_step%0d: led=%b pos=%0d, want led=%b pos=%0d", i, led, position,
                 (i % 2 == 0) ? 5'b11111 : 5'b00000, p0);
      end
    end
    wait_tick("blink"); clk_step();
    mode = 3'd6;
    clk_step();
    tests++;
    if (led !== 5'b00000 || position !== p0) begin
      fails++;
      $display("FAIL reserved_mode: led=%b pos=%0d, want 00000 %0d", led, position, p0);
    end
  endtask

  task automatic test_pause();
    logic [2:0] p0;
    mode = MODE_SHIFT_UP; speed = 2'd3;
    do_reset();
    wait_tick("pause"); clk_step();
    pause = 1'b1;
    p0 = position;
    for (int i = 0; i < 3; i++) begin
      wait_tick("pause");
      tests++;
      if (tick !== 1'b1) begin
        fails++;
        $display("FAIL pause_tick%0d: tick=%b, want 1", i, tick);
      end
      clk_step();
      tests++;
      if (position !== p0) begin
        fails++;
        $display("FAIL pause_hold%0d: pos=%0d, want %0d", i, position, p0);
      end
    end
    pause = 1'b0;
    wait_tick("pause");
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    tests++;
    if (position !== 3'd0 || led !== 5'b0 || tick !== 1'b0) begin
      fails++;
      $display("FAIL reset_on_tick: pos=%0d led=%b tick=%b, want 0 00000 0", position, led, tick);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) pause = !pause;
      rst = ($urandom_range(0, 199) == 0);
      clk_step();
      tests++;
      if (led !== 5'(m_led) || position !== 3'(m_pos) || tick !== m_tick) begin
        fails++;
        $display("FAIL random_cyc%0d: led=%b pos=%0d tick=%b, want led=%b pos=%0d tick=%b",
                 i, led, position, tick, 5'(m_led), m_pos, m_tick);
      end
    end
    rst = 1'b0;
    pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_shift_up();
    test_shift_down();
    test_bounce();
    test_fill();
    test_blink();
    test_pause();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
